// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN,
        MDU_WAIT
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control-field widths of the pipeline registers that a bubble zeroes.
    localparam int unsigned WB_W     = 2;
    localparam int unsigned M_W      = 3;
    localparam int unsigned EX_W     = 4;
    localparam int unsigned BUBBLE_W = WB_W + M_W + EX_W;

    // A load in ID/EX whose destination feeds the instruction in IF/ID.
    function automatic logic load_use_hit(input logic       memread,
                                          input logic [4:0] ex_rt,
                                          input logic [4:0] id_rs,
                                          input logic [4:0] id_rt,
                                          input logic       uses_rt);
        return memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives stage fields, receives controls).
// slave:  hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rt;
    logic       ex_memread;
    logic       ex_mdu_op;
    logic       branch_taken;
    logic       mdu_done;

    logic       mdu_start;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       mdu_error;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, ex_mdu_op, branch_taken, mdu_done,
        input  mdu_start, pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
               exmem_flush, mdu_error
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, ex_mdu_op, branch_taken, mdu_done,
        output mdu_start, pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
               exmem_flush, mdu_error
    );
endinterface

// File: rtl/hazard_stat_counters.sv
// Saturating stall / flush event counters.
// Only built when HAZARD_STATS_EN is defined.
`ifdef HAZARD_STATS_EN
module hazard_stat_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && (flush_events != '1)) flush_events <= flush_events + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle MDU stalls with
// done handshake and timeout, and wrong-path flush on taken branches.
// Optional statistics counters enabled by HAZARD_STATS_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave ctrl
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    localparam int unsigned       WAIT_W    = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MDU_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mdu_start, pc_write, ifid_write, idex_write;
    logic ifid_flush, idex_flush, exmem_flush, mdu_error;
    logic load_use;

    assign load_use = load_use_hit(ctrl.ex_memread, ctrl.ex_rt, ctrl.id_rs, ctrl.id_rt,
                                   ctrl.id_uses_rt);

    // Next state and all pipeline controls; outputs act at the very next edge.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mdu_start   = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mdu_error   = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ctrl.branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ctrl.ex_mdu_op) begin
                        mdu_start = 1'b1;
                        // A same-cycle done needs no stall at all.
                        if (!ctrl.mdu_done) begin
                            pc_write    = 1'b0;
                            ifid_write  = 1'b0;
                            idex_write  = 1'b0;
                            exmem_flush = 1'b1;
                            state_d     = MDU_WAIT;
                            wait_cnt_d  = '0;
                        end
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (ctrl.mdu_done) begin
                        state_d = RUN;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        mdu_error = 1'b1;
                        state_d   = RUN;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b1;
                        wait_cnt_d  = wait_cnt_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // FSM state and MDU wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign ctrl.mdu_start   = mdu_start;
    assign ctrl.pc_write    = pc_write;
    assign ctrl.ifid_write  = ifid_write;
    assign ctrl.idex_write  = idex_write;
    assign ctrl.ifid_flush  = ifid_flush;
    assign ctrl.idex_flush  = idex_flush;
    assign ctrl.exmem_flush = exmem_flush;
    assign ctrl.mdu_error   = mdu_error;

`ifdef HAZARD_STATS_EN
    logic stall_inc, flush_inc;

    assign stall_inc = !rst && !pc_write;
    assign flush_inc = !rst && (state_q == RUN) && ctrl.branch_taken;

    hazard_stat_counters #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (stall_inc),
        .flush_inc    (flush_inc),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MDU_TIMEOUT=8).
// Expected controls are pushed per cycle by a behavioural model; a negedge
// monitor pops and compares against the DUT.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CW      = 32;

    typedef struct {
        string       name;
        logic [7:0]  ctl;  // {start, pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f, err}
        logic [31:0] stalls;
        logic [31:0] flushes;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stall_cycles, flush_events;
`endif

    pipeline_hazard_ctrl #(
        .MDU_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl         (bus.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: number of cycles already spent waiting on the MDU, -1 = not waiting.
    int      waited = -1;
    longint  m_stalls = 0;
    longint  m_flushes = 0;
    longint  sat_max = (64'd1 << CW) - 1;

    task automatic apply(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses, input logic [4:0] xrt, input logic mrd,
                         input logic mdu, input logic br, input logic done, input string nm);
        exp_t e;
        logic start, stall, bubble, flush_br, err;
        @(posedge clk);
        #1;
        rst              = r;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rt   = uses;
        bus.ex_rt        = xrt;
        bus.ex_memread   = mrd;
        bus.ex_mdu_op    = mdu;
        bus.branch_taken = br;
        bus.mdu_done     = done;

        e.name    = nm;
        e.stalls  = m_stalls[31:0];
        e.flushes = m_flushes[31:0];
        start = 0; stall = 0; bubble = 0; flush_br = 0; err = 0;

        if (r) begin
            e.ctl = 8'b0_000_111_0;
            waited = -1;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            if (waited >= 0) begin
                if (done) waited = -1;
                else if (waited == TIMEOUT - 1) begin err = 1; waited = -1; end
                else begin stall = 1; waited++; end
            end else if (br) begin
                flush_br = 1;
            end else if (mdu) begin
                start = 1;
                if (!done) begin stall = 1; waited = 0; end
            end else if (mrd && xrt != 0 && (xrt == rs || (uses && xrt == rt))) begin
                bubble = 1;
            end
            e.ctl = {start, !(stall || bubble), !(stall || bubble), !stall,
                     flush_br, flush_br || bubble, stall, err};
            if ((stall || bubble) && m_stalls < sat_max) m_stalls++;
            if (flush_br && m_flushes < sat_max) m_flushes++;
        end
        exp_q.push_back(e);
    endtask

    // Quiet cycle with no hazards present.
    task automatic idle(input string nm);
        apply(0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    // Monitor: compare the DUT against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [7:0] got;
            e   = exp_q.pop_front();
            got = {bus.mdu_start, bus.pc_write, bus.ifid_write, bus.idex_write,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.mdu_error};
            n_vec++;
            if (got !== e.ctl) begin
                n_err++;
                $display("FAIL %s @%0t: ctl got %b expected %b", e.name, $time, got, e.ctl);
            end
`ifdef HAZARD_STATS_EN
            n_vec++;
            if (stall_cycles !== e.stalls || flush_events !== e.flushes) begin
                n_err++;
                $display("FAIL %s_stats @%0t: got %0d/%0d expected %0d/%0d", e.name, $time,
                         stall_cycles, flush_events, e.stalls, e.flushes);
            end
`endif
        end
    end

    initial begin
        rst = 1'b1;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0; bus.ex_rt = '0;
        bus.ex_memread = 0; bus.ex_mdu_op = 0; bus.branch_taken = 0; bus.mdu_done = 0;

        apply(1, 5'd8, 5'd8, 1, 5'd8, 1, 1, 1, 0, "reset");
        apply(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "reset");
        idle("idle");

        // Load-use on Rs, then self-clears once the load leaves ID/EX.
        apply(0, 5'd8, 5'd2, 0, 5'd8, 1, 0, 0, 0, "load_use_rs");
        apply(0, 5'd8, 5'd2, 0, 5'd8, 0, 0, 0, 0, "load_use_release");
        apply(0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, "zero_reg");
        apply(0, 5'd1, 5'd9, 0, 5'd9, 1, 0, 0, 0, "rt_unused");
        apply(0, 5'd1, 5'd9, 1, 5'd9, 1, 0, 0, 0, "load_use_rt");
        apply(0, 5'd8, 5'd8, 1, 5'd8, 1, 0, 1, 0, "branch_prio");

        // MDU handshake: done arrives five cycles after the op.
        apply(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "reset");
        apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, "mdu_start");
        for (int i = 0; i < 4; i++) apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, i[0], 0, "mdu_wait");
        apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 1, "mdu_done");
        idle("mdu_after");
        apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 1, "mdu_same_cycle_done");

        // Timeout: no done ever arrives.
        apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, "to_start");
        for (int i = 0; i < int'(TIMEOUT); i++) apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, "to_wait");
        idle("to_after");

        // Reset during the wait: no error, no restart without a new op.
        apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, "rstmid_start");
        for (int i = 0; i < 3; i++) apply(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, "rstmid_wait");
        apply(1, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, "rstmid_reset");
        for (int i = 0; i < 3; i++) idle("rstmid_after");

        // Random traffic on a small register set to provoke frequent matches.
        for (int i = 0; i < 3000; i++) begin
            logic r, mrd, mdu;
            r   = ($urandom_range(0, 99) == 0);
            mrd = ($urandom_range(0, 2) == 0);
            mdu = !mrd && ($urandom_range(0, 5) == 0);
            apply(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), mrd, mdu, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), "random");
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
